// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer with a show-ahead byte FIFO, error counter and busy watchdog.
// Optional build macro UART_RX_CTRL_DROP_OLDEST_EN: overflow overwrites the oldest byte.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1200,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_busy,
  input  logic                     rx_err,
  output logic                     rx_enable,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic [7:0]               err_count,
  output logic [1:0]               state
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRecv  = 2'd2,
    StFlush = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              timeout;
  logic              rx_enable_q;

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StArmed;
      end
      StArmed: begin
        if (rx_busy) begin
          state_d = StRecv;
          wdog_d  = '0;
        end
      end
      StRecv: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (!rx_busy) begin
          state_d = StArmed;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = StFlush;
          wdog_d  = '0;
          timeout = 1'b1;
        end
      end
      StFlush: begin
        state_d = StArmed;
      end
      default: state_d = StIdle;
    endcase
    // stop overrides everything, including a timeout landing on the same cycle
    if (stop) begin
      state_d = StIdle;
      wdog_d  = '0;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wdog_q      <= '0;
      rx_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      rx_enable_q <= (state_d == StArmed) || (state_d == StRecv);
    end
  end

  assign rx_enable = rx_enable_q;
  assign state     = state_q;

  // Byte FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          rdy_q;
  logic          overrun_q, overrun_d;
  logic          push, pop, full, ovf, wr_en, rd_adv;

  assign push      = rx_ready & ~rdy_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign out_data  = mem_q[rd_q];
  assign count     = count_q;
  assign overrun   = overrun_q;

  always_comb begin
    ovf    = push & full & ~pop;
    wr_en  = push & (~full | pop);
    rd_adv = pop;
`ifdef UART_RX_CTRL_DROP_OLDEST_EN
    // Full: tail equals head, so writing there and advancing both discards the oldest
    if (ovf) begin
      wr_en  = 1'b1;
      rd_adv = 1'b1;
    end
`endif
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d    = rd_adv ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (wr_en && !rd_adv)      count_d = count_q + (AW+1)'(1);
    else if (rd_adv && !wr_en) count_d = count_q - (AW+1)'(1);
    overrun_d = overrun_q;
    if (start) overrun_d = 1'b0;
    if (ovf)   overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      rdy_q     <= rx_ready;
      overrun_q <= overrun_d;
    end
  end

  // Error counter: rx_err and timeout may both land in one cycle
  logic [8:0] err_sum;
  logic [7:0] err_q;

  assign err_sum   = {1'b0, err_q} + {8'd0, rx_err} + {8'd0, timeout};
  assign err_count = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller and byte buffer that sequences the UART receiver datapath. It arms and disarms the receiver's enable, captures each completed byte into a small show-ahead FIFO, and counts framing/parity errors. A watchdog forces the receiver to resynchronise if a frame stalls. It sits between the UART receiver and the consuming logic (command decoder / top-level display) and offers a valid/ready byte stream.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 1200, max clk cycles rx_busy may stay high before a forced resync; minimum 2.
CNT_W, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: arm receiver
stop  in  1  one-cycle pulse: disarm receiver
rx_data  in  8  receiver data_out
rx_ready  in  1  receiver data_ready (level; a byte is taken on its rising edge)
rx_busy  in  1  receiver receiving flag
rx_err  in  1  one-cycle pulse: receiver rejected a frame (parity)
rx_enable  out  1  drives receiver enable
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head when out_valid is high
count  out  $clog2(DEPTH)+1  current FIFO occupancy
overrun  out  1  sticky: a byte was lost
err_count  out  8  saturating count of rx_err pulses plus timeouts
state  out  2  current FSM state, for debug LEDs

Behaviour:
- Reset (async, rst high): state=IDLE, rx_enable=0, FIFO empty, count=0, out_valid=0, out_data=0, overrun=0, err_count=0, watchdog=0, rx_ready edge register=0.
- FSM states, encoded IDLE=0, ARMED=1, RECV=2, FLUSH=3:
  - IDLE: rx_enable=0. start -> ARMED.
  - ARMED: rx_enable=1. rx_busy=1 -> RECV and clear watchdog. stop -> IDLE.
  - RECV: rx_enable=1. Watchdog increments each cycle.
    - rx_busy falls -> ARMED.
    - Watchdog reaches TIMEOUT_CYCLES-1 with rx_busy still 1 -> FLUSH, err_count+1.
    - stop -> IDLE.
  - FLUSH: rx_enable=0 for exactly one cycle, then ARMED. stop during FLUSH -> IDLE.
- stop has priority over start and over every other transition. start outside IDLE is ignored.
- rx_enable is a registered output taken directly from the state decode.
- Byte capture:
  - push occurs on the cycle rx_ready=1 while the previous sampled rx_ready=0; rx_data is sampled that cycle.
  - Captures happen in every state, including IDLE, so a byte completing during stop is not lost.
  - out_valid and count update on the next clock edge (1-cycle latency).
- Pop: out_valid & out_ready. The head advances on the edge and out_data shows the next entry the following cycle.
- FIFO rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is a separate register.
  - Full with push and no pop: the byte is dropped, overrun set, count stays DEPTH.
  - Full with push and pop in the same cycle: both occur, count unchanged, no overrun.
  - Empty with pop: ignored; out_ready is don't-care while out_valid=0.
  - Empty with push and pop in the same cycle: the push is stored and the pop is ignored.
- overrun clears only on rst or on a start pulse.
- err_count: +1 per rx_err pulse and per timeout, saturating at 255. rx_err and a timeout in the same cycle add 2, still saturating.
- Mid-operation reset clears everything immediately, regardless of the clock.

Optional Feature:
UART_RX_CTRL_DROP_OLDEST_EN
- Defined: a push while full with no pop overwrites the oldest entry. The head advances and the new byte is written at the tail. count stays DEPTH and overrun is still set.
- Undefined: the newest byte is dropped, as in Behaviour.

Test Plan:
- rst; start; rx_ready rising edge with rx_data=8'hA5 -> next cycle out_valid=1, out_data=8'hA5, count=1; out_ready pulse -> count=0, out_valid=0.
- Push 8'h01..8'h05 with DEPTH=4 and out_ready=0 -> count=4, overrun=1, pops return 01,02,03,04. With UART_RX_CTRL_DROP_OLDEST_EN defined the pops return 02,03,04,05.
- FIFO full, push 8'h77 and pop in the same cycle -> count stays 4, overrun=0, 8'h77 read last.
- start, rx_busy held high for TIMEOUT_CYCLES -> state RECV then FLUSH; rx_enable=0 for exactly one cycle; err_count=1; state returns to ARMED.
- Three rx_err pulses; then 260 more -> err_count=3, then saturates at 255.
- rst asserted mid-RECV with count=2 -> immediately state=IDLE, rx_enable=0, count=0, out_valid=0, overrun=0.
